program_loader: RTL and testbench

- Writer side of the instruction-memory byte-load interface.
- Takes received bytes from a one-cycle-strobe byte source (the UART receiver) and emits exactly one write-enable pulse per byte toward instruction fetch.
- Tracks 32-bit word boundaries, detects the halt instruction, and on completion pulses the PC reset so fetch restarts at address 0.
- Sits between the UART RX and instruction_fetch, under the debug unit's command.

---
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: writer side of the instruction-memory byte-load interface.
// Bytes arriving from the UART receiver are forwarded one per write pulse,
// assembled into big-endian 32-bit words, and the load ends either on the halt
// word (DONE, with a one-cycle PC reset pulse) or on memory overflow (ERROR).
module program_loader #(
    parameter int                  NB_DATA          = 32,
    parameter int                  NB_BYTE          = 8,
    parameter int                  MEM_DEPTH_BYTES  = 1024,
    parameter int                  NB_COUNT         = 11,
    parameter logic [NB_DATA-1:0]  HALT_INSTRUCTION = 32'hFFFFFFFF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_done,
    output logic [NB_BYTE-1:0]  o_load_program_byte,
    output logic                o_load_program_write_enable,
    output logic                o_pc_reset,
    output logic                o_loading,
    output logic                o_program_loaded,
    output logic                o_error,
    output logic [NB_COUNT-1:0] o_byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [NB_COUNT-1:0] LAST_COUNT = NB_COUNT'(MEM_DEPTH_BYTES);

    state_t               state;
    state_t               state_next;
    logic [NB_DATA-1:0]   word_reg;
    logic [NB_DATA-1:0]   word_next;
    logic [NB_DATA-1:0]   word_assembled;
    logic [NB_BYTE-1:0]   byte_reg;
    logic [NB_BYTE-1:0]   byte_next;
    logic                 write_enable_reg;
    logic                 write_enable_next;
    logic                 pc_reset_reg;
    logic                 pc_reset_next;
    logic [NB_COUNT-1:0]  count_reg;
    logic [NB_COUNT-1:0]  count_next;
    logic [NB_COUNT-1:0]  count_inc;

    // The word as it will look once the incoming byte is shifted in; the first
    // byte of a word ends up in the most significant position.
    assign word_assembled = {word_reg[NB_DATA-NB_BYTE-1:0], i_rx_data};
    assign count_inc      = count_reg + NB_COUNT'(1);

    // Next-state and next-output logic; every registered value holds by default.
    always_comb begin
        state_next        = state;
        word_next         = word_reg;
        byte_next         = byte_reg;
        write_enable_next = 1'b0;
        pc_reset_next     = 1'b0;
        count_next        = count_reg;

        case (state)
            IDLE, DONE, ERROR: begin
                // A strobe coinciding with the start command is deliberately dropped.
                if (i_start) begin
                    state_next = LOAD;
                    count_next = '0;
                    word_next  = '0;
                end
            end
            LOAD: begin
                if (i_rx_done) begin
                    byte_next         = i_rx_data;
                    write_enable_next = 1'b1;
                    count_next        = count_inc;
                    word_next         = word_assembled;
                    if (count_reg[1:0] == 2'b11) begin
                        // Halt on the final word wins over the overflow check.
                        if (word_assembled == HALT_INSTRUCTION) begin
                            state_next    = DONE;
                            pc_reset_next = 1'b1;
                        end else if (count_inc == LAST_COUNT) begin
                            state_next = ERROR;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with synchronous reset; memory is left untouched.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= IDLE;
            word_reg         <= '0;
            byte_reg         <= '0;
            write_enable_reg <= 1'b0;
            pc_reset_reg     <= 1'b0;
            count_reg        <= '0;
        end else begin
            state            <= state_next;
            word_reg         <= word_next;
            byte_reg         <= byte_next;
            write_enable_reg <= write_enable_next;
            pc_reset_reg     <= pc_reset_next;
            count_reg        <= count_next;
        end
    end

    assign o_load_program_byte         = byte_reg;
    assign o_load_program_write_enable = write_enable_reg;
    assign o_pc_reset                  = pc_reset_reg;
    assign o_byte_count                = count_reg;
    assign o_loading                   = (state == LOAD);
    assign o_program_loaded            = (state == DONE);
    assign o_error                     = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Instance A uses the
// default 1024-byte memory; instance B uses an 8-byte memory for overflow and
// last-word-halt cases. Expected bytes are queued when strobes are driven and
// popped whenever a write pulse is observed.
module tb_program_loader;

    logic        clock;
    logic        reset;

    logic        start_a, rx_done_a;
    logic [7:0]  rx_data_a;
    logic [7:0]  byte_a;
    logic        we_a, pc_a, loading_a, loaded_a, error_a;
    logic [10:0] count_a;

    logic        start_b, rx_done_b;
    logic [7:0]  rx_data_b;
    logic [7:0]  byte_b;
    logic        we_b, pc_b, loading_b, loaded_b, error_b;
    logic [3:0]  count_b;

    int          assertions = 0;
    int          failures   = 0;
    int          pc_count_a = 0;
    int          pc_count_b = 0;
    logic [7:0]  queue_a[$];
    logic [7:0]  queue_b[$];

    program_loader dut_a (
        .i_clock                     (clock),
        .i_reset                     (reset),
        .i_start                     (start_a),
        .i_rx_data                   (rx_data_a),
        .i_rx_done                   (rx_done_a),
        .o_load_program_byte         (byte_a),
        .o_load_program_write_enable (we_a),
        .o_pc_reset                  (pc_a),
        .o_loading                   (loading_a),
        .o_program_loaded            (loaded_a),
        .o_error                     (error_a),
        .o_byte_count                (count_a)
    );

    program_loader #(
        .MEM_DEPTH_BYTES (8),
        .NB_COUNT        (4)
    ) dut_b (
        .i_clock                     (clock),
        .i_reset                     (reset),
        .i_start                     (start_b),
        .i_rx_data                   (rx_data_b),
        .i_rx_done                   (rx_done_b),
        .o_load_program_byte         (byte_b),
        .o_load_program_write_enable (we_b),
        .o_pc_reset                  (pc_b),
        .o_loading                   (loading_b),
        .o_program_loaded            (loaded_b),
        .o_error                     (error_b),
        .o_byte_count                (count_b)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard for instance A: every write pulse must match the oldest queued byte.
    always @(negedge clock) begin
        if (pc_a) pc_count_a++;
        if (we_a) begin
            if (queue_a.size() == 0) check_output("a_spurious_we", 32'(we_a), 32'd0);
            else check_output("a_byte", 32'(byte_a), 32'(queue_a.pop_front()));
        end
    end

    // Scoreboard for instance B.
    always @(negedge clock) begin
        if (pc_b) pc_count_b++;
        if (we_b) begin
            if (queue_b.size() == 0) check_output("b_spurious_we", 32'(we_b), 32'd0);
            else check_output("b_byte", 32'(byte_b), 32'(queue_b.pop_front()));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clock);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Drive one strobe, verify the write pulse appears (or not) one edge later.
    task automatic apply_stimulus(input bit which, input logic [7:0] data, input bit expect_write, input int gap);
        @(negedge clock);
        if (which) begin
            rx_data_b = data; rx_done_b = 1'b1;
            if (expect_write) queue_b.push_back(data);
        end else begin
            rx_data_a = data; rx_done_a = 1'b1;
            if (expect_write) queue_a.push_back(data);
        end
        @(posedge clock);
        #1;
        check_output(which ? "b_we_latency" : "a_we_latency", 32'(which ? we_b : we_a), 32'(expect_write));
        @(negedge clock);
        rx_done_a = 1'b0;
        rx_done_b = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic check_all_zero_a(input string tag);
        check_output({tag, "_byte"},    32'(byte_a),    32'd0);
        check_output({tag, "_we"},      32'(we_a),      32'd0);
        check_output({tag, "_pc"},      32'(pc_a),      32'd0);
        check_output({tag, "_loading"}, 32'(loading_a), 32'd0);
        check_output({tag, "_loaded"},  32'(loaded_a),  32'd0);
        check_output({tag, "_error"},   32'(error_a),   32'd0);
        check_output({tag, "_count"},   32'(count_a),   32'd0);
    endtask

    initial begin
        logic [7:0] prog1 [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] skew  [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        logic [7:0] burst [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [7:0] fill  [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        reset = 1'b1;
        start_a = 1'b0; rx_done_a = 1'b0; rx_data_a = '0;
        start_b = 1'b0; rx_done_b = 1'b0; rx_data_b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all_zero_a("reset");
        check_output("b_reset_error", 32'(error_b), 32'd0);

        // Strobes in IDLE are ignored.
        apply_stimulus(1'b0, 8'h5A, 1'b0, 2);
        check_output("idle_count", 32'(count_a), 32'd0);

        // Program ending in halt, one strobe every 16 cycles.
        pulse_start(1'b0);
        check_output("start_loading", 32'(loading_a), 32'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, prog1[i], 1'b1, 15);
        check_output("first_word_count",   32'(count_a),   32'd4);
        check_output("first_word_loading", 32'(loading_a), 32'd1);
        for (int i = 4; i < 7; i++) apply_stimulus(1'b0, prog1[i], 1'b1, 15);
        @(negedge clock);
        rx_data_a = prog1[7]; rx_done_a = 1'b1; queue_a.push_back(prog1[7]);
        @(posedge clock);
        #1;
        check_output("halt_pc_reset", 32'(pc_a),      32'd1);
        check_output("halt_loaded",   32'(loaded_a),  32'd1);
        check_output("halt_loading",  32'(loading_a), 32'd0);
        check_output("halt_count",    32'(count_a),   32'd8);
        @(negedge clock);
        rx_done_a = 1'b0;
        repeat (4) @(negedge clock);
        check_output("halt_pc_pulses", 32'(pc_count_a), 32'd1);
        apply_stimulus(1'b0, 8'h77, 1'b0, 2);
        check_output("done_count_hold", 32'(count_a), 32'd8);

        // Halt bytes straddling a word boundary must not terminate the load.
        pulse_start(1'b0);
        check_output("restart_count",  32'(count_a),  32'd0);
        check_output("restart_loaded", 32'(loaded_a), 32'd0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, skew[i], 1'b1, 3);
        check_output("skew_loading", 32'(loading_a), 32'd1);
        check_output("skew_count",   32'(count_a),   32'd8);
        check_output("skew_pc",      32'(pc_count_a), 32'd1);

        // Back-to-back strobes on four consecutive cycles.
        @(negedge clock);
        rx_done_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data_a = burst[i];
            queue_a.push_back(burst[i]);
            @(posedge clock);
            #1;
            check_output("burst_we", 32'(we_a), 32'd1);
            @(negedge clock);
        end
        rx_done_a = 1'b0;
        repeat (2) @(negedge clock);
        check_output("burst_count", 32'(count_a), 32'd12);

        // Reset in the middle of a load aborts it.
        do_reset();
        pulse_start(1'b0);
        apply_stimulus(1'b0, 8'h11, 1'b1, 1);
        apply_stimulus(1'b0, 8'h22, 1'b1, 1);
        check_output("pre_abort_count", 32'(count_a), 32'd2);
        do_reset();
        check_all_zero_a("abort");
        apply_stimulus(1'b0, 8'h33, 1'b0, 2);
        check_output("abort_count", 32'(count_a), 32'd0);

        // Start coinciding with a strobe starts the load but drops that byte.
        @(negedge clock);
        start_a = 1'b1; rx_done_a = 1'b1; rx_data_a = 8'hAA;
        @(posedge clock);
        #1;
        check_output("start_strobe_we", 32'(we_a), 32'd0);
        @(negedge clock);
        start_a = 1'b0; rx_done_a = 1'b0;
        check_output("start_strobe_loading", 32'(loading_a), 32'd1);
        check_output("start_strobe_count",   32'(count_a),   32'd0);

        // Instance B: overflow of an 8-byte memory.
        pulse_start(1'b1);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, fill[i], 1'b1, 2);
        check_output("ovf_error",   32'(error_b),    32'd1);
        check_output("ovf_loading", 32'(loading_b),  32'd0);
        check_output("ovf_count",   32'(count_b),    32'd8);
        check_output("ovf_no_pc",   32'(pc_count_b), 32'd0);
        apply_stimulus(1'b1, 8'h99, 1'b0, 2);
        pulse_start(1'b1);
        check_output("ovf_restart_loading", 32'(loading_b), 32'd1);
        check_output("ovf_restart_count",   32'(count_b),   32'd0);
        check_output("ovf_restart_error",   32'(error_b),   32'd0);

        // Instance B: halt on the last word wins over overflow.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, fill[i], 1'b1, 2);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'hFF, 1'b1, 2);
        check_output("last_halt_loaded", 32'(loaded_b),   32'd1);
        check_output("last_halt_error",  32'(error_b),    32'd0);
        check_output("last_halt_pc",     32'(pc_count_b), 32'd1);
        check_output("last_halt_count",  32'(count_b),    32'd8);

        repeat (4) @(negedge clock);
        check_output("a_queue_empty", 32'(queue_a.size()), 32'd0);
        check_output("b_queue_empty", 32'(queue_b.size()), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
